mipi_rx_raw_depacker: RTL and testbench

//  Multi-format MIPI CSI-2 RAW depacker: successor to the fixed RAW10/RAW12 depackers.

---
 rtl/mipi_rx_raw_depacker.sv | 189 ++++++++++++++++++
 tb/tb_mipi_rx_raw_depacker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mipi_rx_raw_depacker.sv
// Multi-format CSI-2 RAW8/10/12/14 depacker: LANES bytes in, LANES 16-bit pixels out per emit.
// Optional line statistics (pixel_count_o, residue_err_o) under `define DEPACK_STATS_EN.

module mipi_rx_raw_unpack4 (
   input  logic [1:0]       mode_i,
   input  logic [6:0][7:0]  grp_i,
   output logic [3:0][13:0] pix_o
);
   logic [23:0] lsb;
   assign lsb = {grp_i[6], grp_i[5], grp_i[4]};

   always_comb begin
      pix_o = '0;
      for (int k = 0; k < 4; k++) begin
         case (mode_i)
            2'd0:    pix_o[k] = {6'd0, grp_i[k]};
            2'd1:    pix_o[k] = {4'd0, grp_i[k], grp_i[4][2*k +: 2]};
            // RAW12 packs two pixels per 3 bytes; the second pair starts at byte 3
            2'd2:    pix_o[k] = {2'd0, grp_i[(k%2) + 3*(k/2)], grp_i[2 + 3*(k/2)][4*(k%2) +: 4]};
            default: pix_o[k] = {grp_i[k], lsb[6*k +: 6]};
         endcase
      end
   end
endmodule

module mipi_rx_raw_depacker #(
   parameter int LANES = 4
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic [1:0]          mode_i,
   input  logic                data_valid_i,
   input  logic [8*LANES-1:0]  data_i,
   output logic                output_valid_o,
   output logic [16*LANES-1:0] output_o
`ifdef DEPACK_STATS_EN
   ,
   output logic [15:0]         pixel_count_o,
   output logic                residue_err_o
`endif
);
   localparam int BUF_BYTES = 3*LANES;
   localparam int CW        = $clog2(BUF_BYTES+1);
   localparam int NG        = LANES/4;

   function automatic int need_f(input int m);
      return LANES*(4+m)/4;
   endfunction

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                          state_q, state_d;
   logic [1:0]                      mode_q, mode_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [BUF_BYTES-1:0][7:0]       buf_q, buf_d;
   logic                            vld_q, vld_d;
   logic [LANES-1:0][15:0]          out_q, out_d;

   logic [1:0]                      line_mode;
   logic [BUF_BYTES-1:0][7:0]       wbuf;
   logic [3:0][BUF_BYTES-1:0][7:0]  sh;
   logic [NG-1:0][6:0][7:0]         grp;
   logic [NG-1:0][3:0][13:0]        gpix;
   logic [LANES-1:0][15:0]          pix;
   int                              need, tot;
   logic                            emit;

   // First beat of a line uses mode_i directly since mode_q is only latched on it
   assign line_mode = (state_q == S_IDLE) ? mode_i : mode_q;

   always_comb begin
      wbuf = buf_q;
      for (int j = 0; j < BUF_BYTES; j++)
         for (int i = 0; i < LANES; i++)
            if (int'(cnt_q) + i == j) wbuf[j] = data_i[8*i +: 8];
   end

   always_comb begin
      need = need_f(int'(line_mode));
      tot  = int'(cnt_q) + LANES;
      emit = data_valid_i && (tot >= need);
   end

   for (genvar m = 0; m < 4; m++) begin : g_sh
      for (genvar j = 0; j < BUF_BYTES; j++) begin : g_b
         if (j + need_f(m) < BUF_BYTES) begin : g_in
            assign sh[m][j] = wbuf[j + need_f(m)];
         end else begin : g_zero
            assign sh[m][j] = '0;
         end
      end
   end

   for (genvar g = 0; g < NG; g++) begin : g_grp
      for (genvar i = 0; i < 7; i++) begin : g_byte
         assign grp[g][i] = (line_mode == 2'd0) ? wbuf[4*g+i] :
                            (line_mode == 2'd1) ? wbuf[5*g+i] :
                            (line_mode == 2'd2) ? wbuf[6*g+i] : wbuf[7*g+i];
      end
      mipi_rx_raw_unpack4 u_unpack (
         .mode_i (line_mode),
         .grp_i  (grp[g]),
         .pix_o  (gpix[g])
      );
   end

   // Pixel 0 lands in the most significant slot
   always_comb begin
      pix = '0;
      for (int g = 0; g < NG; g++)
         for (int k = 0; k < 4; k++)
            pix[LANES-1-(4*g+k)] = {2'b00, gpix[g][k]};
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      vld_d   = 1'b0;
      out_d   = '0;
      if (data_valid_i) begin
         if (state_q == S_IDLE) begin
            state_d = S_ACTIVE;
            mode_d  = mode_i;
         end
         if (emit) begin
            vld_d = 1'b1;
            out_d = pix;
            cnt_d = CW'(tot - need);
            buf_d = sh[line_mode];
         end else begin
            cnt_d = CW'(tot);
            buf_d = wbuf;
         end
      end else begin
         state_d = S_IDLE;
         cnt_d   = '0;
         buf_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         mode_q  <= 2'd0;
         cnt_q   <= '0;
         buf_q   <= '0;
         vld_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         vld_q   <= vld_d;
         out_q   <= out_d;
      end
   end

   assign output_valid_o = vld_q;
   assign output_o       = out_q;

`ifdef DEPACK_STATS_EN
   logic [15:0] pc_q, pc_d;
   logic        rerr_q, rerr_d;

   always_comb begin
      pc_d   = pc_q;
      rerr_d = rerr_q;
      if (data_valid_i && state_q == S_IDLE) pc_d = '0;
      if (emit) pc_d = pc_d + 16'(LANES);
      if (state_q == S_ACTIVE && !data_valid_i && cnt_q != '0) rerr_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pc_q   <= '0;
         rerr_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         rerr_q <= rerr_d;
      end
   end

   assign pixel_count_o = pc_q;
   assign residue_err_o = rerr_q;
`endif
endmodule

// File: tb/tb_mipi_rx_raw_depacker.sv
// Bench for mipi_rx_raw_depacker (LANES=4): constant vectors, model-driven lines, reset corners.
module tb_mipi_rx_raw_depacker;
   localparam int L = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    mode;
   logic          dv;
   logic [8*L-1:0]  din;
   logic          ov;
   logic [16*L-1:0] dout;
`ifdef DEPACK_STATS_EN
   logic [15:0]   pcnt;
   logic          rerr;
`endif

   always #5 clk = ~clk;

   mipi_rx_raw_depacker #(.LANES(L)) dut (
      .clk_i          (clk),
      .reset_n_i      (rst_n),
      .mode_i         (mode),
      .data_valid_i   (dv),
      .data_i         (din),
      .output_valid_o (ov),
      .output_o       (dout)
`ifdef DEPACK_STATS_EN
      ,
      .pixel_count_o  (pcnt),
      .residue_err_o  (rerr)
`endif
   );

   typedef struct { int cyc; logic [63:0] pix; } exp_t;
   typedef struct {
      logic [1:0]  mode;
      int          nb;
      logic [31:0] beat[4];
      int          nexp;
      int          ebeat[2];
      logic [63:0] epix[2];
      int          resid;
   } vec_t;

   exp_t sb[$];
   vec_t vt[5];
   int   checks = 0, errors = 0, cyc = 0, n_emit = 0, mdl_pc = 0, base;
   bit   mdl_rerr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] p);
      exp_t e;
      e.cyc = cyc + 1;
      e.pix = p;
      sb.push_back(e);
   endtask

   task automatic mon();
      exp_t e;
      if (ov) begin
         n_emit++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_emit act=%h exp=none", dout);
         end else begin
            e = sb.pop_front();
            chk("pix", dout, e.pix);
            chk("latency", 64'(cyc), 64'(e.cyc));
         end
      end else begin
         chk("idle_out", dout, 64'd0);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
   endtask

   task automatic stat_chk();
`ifdef DEPACK_STATS_EN
      chk("pixel_count", 64'(pcnt), 64'(mdl_pc));
      chk("residue_err", 64'(rerr), 64'(mdl_rerr));
`endif
   endtask

   task automatic drain();
      tick(); dv = 1'b0;
      tick(); tick();
      chk("drain", 64'(sb.size()), 64'd0);
      sb.delete();
      stat_chk();
   endtask

   function automatic logic [63:0] model(input logic [1:0] m, input logic [7:0] g[7]);
      logic [15:0] p[4];
      logic [23:0] s;
      s = {g[6], g[5], g[4]};
      for (int k = 0; k < 4; k++) begin
         case (m)
            2'd0: p[k] = 16'(g[k]);
            2'd1: p[k] = 16'(int'(g[k])*4 + ((int'(g[4]) >> (2*k)) & 3));
            2'd2: p[k] = 16'(int'(g[k%2 + 3*(k/2)])*16 + ((int'(g[2 + 3*(k/2)]) >> (4*(k%2))) & 15));
            default: p[k] = 16'(int'(g[k])*64 + ((int'(s) >> (6*k)) & 63));
         endcase
      end
      return {p[0], p[1], p[2], p[3]};
   endfunction

   task automatic run_vec(input vec_t v);
      mdl_pc = 0;
      for (int b = 0; b < v.nb; b++) begin
         tick();
         dv = 1'b1; mode = v.mode; din = v.beat[b];
         for (int e = 0; e < v.nexp; e++)
            if (v.ebeat[e] == b) begin
               push_exp(v.epix[e]);
               mdl_pc += L;
            end
      end
      if (v.resid != 0) mdl_rerr = 1'b1;
      drain();
   endtask

   task automatic run_line(input logic [1:0] m, input int nb, input bit tog);
      logic [7:0]  q[$];
      logic [7:0]  g[7];
      logic [31:0] d;
      int          need;
      need   = L*(4 + int'(m))/4;
      mdl_pc = 0;
      for (int b = 0; b < nb; b++) begin
         tick();
         d = $urandom;
         din = d; dv = 1'b1;
         mode = (b == 0 || !tog) ? m : 2'($urandom);
         for (int i = 0; i < L; i++) q.push_back(d[8*i +: 8]);
         if (q.size() >= need) begin
            for (int i = 0; i < 7; i++) g[i] = (i < need) ? q[i] : 8'h00;
            repeat (need) void'(q.pop_front());
            push_exp(model(m, g));
            mdl_pc += L;
         end
      end
      if (q.size() != 0) mdl_rerr = 1'b1;
      drain();
   endtask

   initial begin
      vt[0] = '{2'd1, 2, '{32'h44332211, 32'h000000E4, 32'h0, 32'h0}, 1, '{1, 0},
                '{64'h0044_0089_00CE_0113, 64'h0}, 3};
      vt[1] = '{2'd2, 2, '{32'h12E1CDAB, 32'h00006534, 32'h0, 32'h0}, 1, '{1, 0},
                '{64'h0AB1_0CDE_0125_0346, 64'h0}, 2};
      vt[2] = '{2'd0, 1, '{32'h04030201, 32'h0, 32'h0, 32'h0}, 1, '{0, 0},
                '{64'h0001_0002_0003_0004, 64'h0}, 0};
      vt[3] = '{2'd3, 2, '{32'h40302010, 32'h009F3AC5, 32'h0, 32'h0}, 1, '{1, 0},
                '{64'h0405_082B_0C33_1027, 64'h0}, 1};
      vt[4] = '{2'd2, 3, '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h0}, 2, '{1, 2},
                '{64'h0113_0223_0446_0556, 64'h0779_0889_0AAC_0BBC}, 0};

      rst_n = 1'b0; dv = 1'b0; mode = 2'd0; din = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(ov), 64'd0);
      chk("rst_out", dout, 64'd0);
      stat_chk();
      rst_n = 1'b1;
      tick();

      // Long RAW12 line first so the sticky residue flag is still clear
      run_line(2'd2, 60, 1'b0);
      chk("raw12_pixels", 64'(mdl_pc), 64'(n_emit*L));

      for (int i = 0; i < 5; i++) run_vec(vt[i]);

      base = n_emit; run_line(2'd0, 8, 1'b0);
      chk("raw8_emits", 64'(n_emit - base), 64'd8);
      base = n_emit; run_line(2'd3, 7, 1'b0);
      chk("raw14_emits", 64'(n_emit - base), 64'd4);
      base = n_emit; run_line(2'd1, 3, 1'b0);
      chk("raw10_short_emits", 64'(n_emit - base), 64'd2);
      run_vec(vt[0]);

      for (int i = 0; i < 12; i++)
         run_line(2'($urandom), int'($urandom_range(1, 16)), 1'b1);

      // Reset mid-line while an emit is on the outputs
      tick(); dv = 1'b1; mode = 2'd1; din = 32'h44332211;
      tick(); din = 32'h000000E4; push_exp(64'h0044_0089_00CE_0113);
      tick(); din = 32'hDEADBEEF;
      @(posedge clk); #1;
      chk("pre_rst_valid", 64'(ov), 64'd1);
      rst_n = 1'b0; #1;
      chk("async_rst_valid", 64'(ov), 64'd0);
      chk("async_rst_out", dout, 64'd0);
      mdl_pc = 0; mdl_rerr = 1'b0;
      stat_chk();
      tick(); dv = 1'b0; rst_n = 1'b1;
      run_vec(vt[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
